// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and fetch FSM encoding for the front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam logic [5:0]  ECODE_ADEF       = 6'h08;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

   typedef logic [0:0] fsm_t;
   localparam fsm_t S_IDLE = 1'b0;
   localparam fsm_t S_REQ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_buf
//  Description : Redirect priority mux plus the redirect-pending holding reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_buf
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        br_flush,
   input  logic [31:0] br_target,
   input  logic        ex_flush,
   input  logic [31:0] ex_entry,
   input  logic        ertn_flush,
   input  logic [31:0] era,
   input  logic        capture,
   input  logic        clear,
   output logic        redir_valid,
   output logic [31:0] redir_target,
   output logic        redir_pend,
   output logic [31:0] redir_pc
);

   logic        redir_pend_d, redir_pend_q;
   logic [31:0] redir_pc_d,   redir_pc_q;

   always_comb begin
      redir_valid = ex_flush | ertn_flush | br_flush;
      if (ex_flush) begin
         redir_target = ex_entry;
      end else if (ertn_flush) begin
         redir_target = era;
      end else begin
         redir_target = br_target;
      end
   end

   // A newer redirect always overwrites the held target.
   always_comb begin
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      if (capture && redir_valid) begin
         redir_pend_d = 1'b1;
         redir_pc_d   = redir_target;
      end else if (clear) begin
         redir_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         redir_pend_q <= 1'b0;
         redir_pc_q   <= 32'd0;
      end else begin
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
      end
   end

   assign redir_pend = redir_pend_q;
   assign redir_pc   = redir_pc_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Fetch PC owner, sram-like request issue and redirect absorb.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        out_ready,
   output logic        out_valid,
   input  logic        br_flush,
   input  logic [31:0] br_target,
   input  logic        ex_flush,
   input  logic [31:0] ex_entry,
   input  logic        ertn_flush,
   input  logic [31:0] era,
   output logic        req,
   output logic [31:0] addr,
   input  logic        addr_ok,
   output logic [31:0] PC_out,
   output logic [31:0] inst_out,
   output logic        inst_valid_out,
   output logic        discard_out,
   output logic        has_exception_out,
   output logic [5:0]  ecode_out,
   output logic [8:0]  esubcode_out
);

   fsm_t        fsm_d, fsm_q;
   logic [31:0] pc_d, pc_q;
   logic        req_d, req_q;
   logic [31:0] addr_d, addr_q;
   logic        adef_d, adef_q;
   logic        out_valid_d, out_valid_q;
   logic [31:0] pc_out_d, pc_out_q;
   logic        inst_valid_d, inst_valid_q;
   logic        has_exc_d, has_exc_q;
   logic [5:0]  ecode_d, ecode_q;
   logic        discard_d, discard_q;
   logic [1:0]  disc_cnt_d, disc_cnt_q;

   logic        redir_valid, redir_pend;
   logic [31:0] redir_target, redir_pc;
   logic        slot_free, accept, drop_accept, take;
   logic        pc_misaligned, adef_load, issue_idle, redir_issue, slot_kill;
   logic [2:0]  disc_total;

   assign slot_free     = !out_valid_q || out_ready;
   assign accept        = (fsm_q == S_REQ) && addr_ok;
   assign drop_accept   = accept && (redir_valid || redir_pend);
   assign take          = accept && !drop_accept;
   assign pc_misaligned = (pc_q[1:0] != 2'b00);
   assign adef_load     = (fsm_q == S_IDLE) && !redir_valid && pc_misaligned && slot_free && !adef_q;
   assign issue_idle    = (fsm_q == S_IDLE) && !redir_valid && !pc_misaligned && slot_free;
   assign redir_issue   = (fsm_q == S_IDLE) && redir_valid && (redir_target[1:0] == 2'b00);
   assign slot_kill     = redir_valid && out_valid_q && !inst_valid_q;

   fetch_redirect_buf u_redirect_buf (
      .clk          (clk),
      .rst          (rst),
      .br_flush     (br_flush),
      .br_target    (br_target),
      .ex_flush     (ex_flush),
      .ex_entry     (ex_entry),
      .ertn_flush   (ertn_flush),
      .era          (era),
      .capture      ((fsm_q == S_REQ) && !addr_ok),
      .clear        (accept),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .redir_pend   (redir_pend),
      .redir_pc     (redir_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q <= S_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // Chain another request only when the wait stage is draining right now.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         S_IDLE:  if (redir_issue || issue_idle) fsm_d = S_REQ;
         S_REQ:   if (accept && (drop_accept || !out_ready)) fsm_d = S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_d   = pc_q;
      req_d  = req_q;
      addr_d = addr_q;
      adef_d = adef_q;
      if (fsm_q == S_IDLE) begin
         if (redir_valid) begin
            pc_d   = redir_target;
            adef_d = 1'b0;
         end
         if (redir_issue) begin
            req_d  = 1'b1;
            addr_d = redir_target;
         end else if (issue_idle) begin
            req_d  = 1'b1;
            addr_d = pc_q;
         end
         if (adef_load) adef_d = 1'b1;
      end else if (accept) begin
         if (drop_accept) begin
            pc_d  = redir_valid ? redir_target : redir_pc;
            req_d = 1'b0;
         end else begin
            pc_d  = addr_q + 32'd4;
            req_d = out_ready;
            if (out_ready) addr_d = addr_q + 32'd4;
         end
      end

      out_valid_d  = out_valid_q;
      pc_out_d     = pc_out_q;
      inst_valid_d = inst_valid_q;
      has_exc_d    = has_exc_q;
      ecode_d      = ecode_q;
      if (redir_valid) begin
         out_valid_d = 1'b0;
      end else if (take) begin
         out_valid_d  = 1'b1;
         pc_out_d     = addr_q;
         inst_valid_d = 1'b0;
         has_exc_d    = 1'b0;
         ecode_d      = 6'd0;
      end else if (adef_load) begin
         out_valid_d  = 1'b1;
         pc_out_d     = pc_q;
         inst_valid_d = 1'b1;
         has_exc_d    = 1'b1;
         ecode_d      = ECODE_ADEF;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // Two discard sources can coincide; the surplus is owed to later cycles.
      disc_total = {1'b0, disc_cnt_q} + {2'b00, drop_accept} + {2'b00, slot_kill};
      discard_d  = (disc_total != 3'd0);
      disc_cnt_d = (disc_total == 3'd0) ? 2'd0 : 2'(disc_total - 3'd1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         addr_q       <= 32'd0;
         adef_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         pc_out_q     <= 32'd0;
         inst_valid_q <= 1'b0;
         has_exc_q    <= 1'b0;
         ecode_q      <= 6'd0;
         discard_q    <= 1'b0;
         disc_cnt_q   <= 2'd0;
      end else begin
         pc_q         <= pc_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         adef_q       <= adef_d;
         out_valid_q  <= out_valid_d;
         pc_out_q     <= pc_out_d;
         inst_valid_q <= inst_valid_d;
         has_exc_q    <= has_exc_d;
         ecode_q      <= ecode_d;
         discard_q    <= discard_d;
         disc_cnt_q   <= disc_cnt_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign req               = req_q;
   assign addr              = addr_q;
   assign PC_out            = pc_out_q;
   assign inst_out          = 32'd0;
   assign inst_valid_out    = inst_valid_q;
   assign discard_out       = discard_q;
   assign has_exception_out = has_exc_q;
   assign ecode_out         = ecode_q;
   assign esubcode_out      = 9'd0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Directed plus randomized bench for if_fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        out_ready = 1'b0;
   logic        br_flush = 1'b0, ex_flush = 1'b0, ertn_flush = 1'b0;
   logic [31:0] br_target = 32'd0, ex_entry = 32'd0, era = 32'd0;
   logic        addr_ok = 1'b0;
   logic        out_valid, req, inst_valid_out, discard_out, has_exception_out;
   logic [31:0] addr, PC_out, inst_out;
   logic [5:0]  ecode_out;
   logic [8:0]  esubcode_out;

   int n_checks = 0;
   int n_pass   = 0;
   int disc_seen = 0;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk               (clk),
      .rst               (rst),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .br_flush          (br_flush),
      .br_target         (br_target),
      .ex_flush          (ex_flush),
      .ex_entry          (ex_entry),
      .ertn_flush        (ertn_flush),
      .era               (era),
      .req               (req),
      .addr              (addr),
      .addr_ok           (addr_ok),
      .PC_out            (PC_out),
      .inst_out          (inst_out),
      .inst_valid_out    (inst_valid_out),
      .discard_out       (discard_out),
      .has_exception_out (has_exception_out),
      .ecode_out         (ecode_out),
      .esubcode_out      (esubcode_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: "busy" means a request is being presented to memory,
   // "owed" counts response drops not yet announced.
   bit          m_busy, m_slot, m_self_inst, m_exc, m_disc, m_adef_done, m_has_redir;
   logic [31:0] m_pc, m_addr, m_slot_pc, m_redir_tgt;
   int          m_owed;

   function automatic void model_reset();
      m_busy = 0; m_slot = 0; m_self_inst = 0; m_exc = 0; m_disc = 0;
      m_adef_done = 0; m_has_redir = 0; m_owed = 0;
      m_pc = 32'h1C00_0000; m_addr = 0; m_slot_pc = 0; m_redir_tgt = 0;
   endfunction

   function automatic void model_step();
      bit          flush, free;
      logic [31:0] tgt;
      bit          n_busy = m_busy, n_slot = m_slot, n_self = m_self_inst, n_exc = m_exc;
      bit          n_adef = m_adef_done, n_has_redir = m_has_redir;
      logic [31:0] n_pc = m_pc, n_addr = m_addr, n_slot_pc = m_slot_pc, n_rt = m_redir_tgt;
      int          owed = m_owed;
      flush = ex_flush || ertn_flush || br_flush;
      tgt   = ex_flush ? ex_entry : (ertn_flush ? era : br_target);
      free  = !m_slot || out_ready;
      if (flush) begin
         if (m_slot && !m_self_inst) owed++;
         n_slot = 0;
      end else if (out_ready) begin
         n_slot = 0;
      end
      if (m_busy) begin
         if (addr_ok) begin
            if (flush || m_has_redir) begin
               owed++;
               n_pc = flush ? tgt : m_redir_tgt;
               n_busy = 0;
               n_has_redir = 0;
            end else begin
               n_slot = 1; n_slot_pc = m_addr; n_self = 0; n_exc = 0;
               n_pc = m_addr + 4;
               n_busy = out_ready;
               if (out_ready) n_addr = m_addr + 4;
            end
         end else if (flush) begin
            n_has_redir = 1;
            n_rt = tgt;
         end
      end else if (flush) begin
         n_pc = tgt;
         n_adef = 0;
         if (tgt[1:0] == 2'b00) begin n_busy = 1; n_addr = tgt; end
      end else if (m_pc[1:0] != 2'b00) begin
         if (free && !m_adef_done) begin
            n_slot = 1; n_slot_pc = m_pc; n_self = 1; n_exc = 1; n_adef = 1;
         end
      end else if (free) begin
         n_busy = 1;
         n_addr = m_pc;
      end
      m_disc = (owed > 0);
      if (owed > 0) owed--;
      m_owed = owed;
      m_busy = n_busy; m_slot = n_slot; m_self_inst = n_self; m_exc = n_exc;
      m_adef_done = n_adef; m_has_redir = n_has_redir;
      m_pc = n_pc; m_addr = n_addr; m_slot_pc = n_slot_pc; m_redir_tgt = n_rt;
   endfunction

   task automatic compare_all();
      check("out_valid", 32'(out_valid), 32'(m_slot));
      check("req", 32'(req), 32'(m_busy));
      check("addr", addr, m_addr);
      check("PC_out", PC_out, m_slot_pc);
      check("inst_out", inst_out, 32'd0);
      check("inst_valid", 32'(inst_valid_out), 32'(m_self_inst));
      check("discard", 32'(discard_out), 32'(m_disc));
      check("has_exc", 32'(has_exception_out), 32'(m_exc));
      check("ecode", 32'(ecode_out), m_exc ? 32'h08 : 32'h0);
      check("esubcode", 32'(esubcode_out), 32'd0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      if (discard_out) disc_seen++;
      br_flush = 0; ex_flush = 0; ertn_flush = 0;
   endtask

   task automatic do_reset();
      rst = 0; addr_ok = 0; out_ready = 0;
      br_flush = 0; ex_flush = 0; ertn_flush = 0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      compare_all();
      rst = 1;
      disc_seen = 0;
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = 32'h1C00_0000 | (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      return t;
   endfunction

   initial begin
      // Reset streaming
      do_reset();
      out_ready = 1; addr_ok = 1;
      tick();
      check("s1_req_c1", 32'(req), 32'd1);
      check("s1_addr_c1", addr, 32'h1C00_0000);
      check("s1_ov_c1", 32'(out_valid), 32'd0);
      tick();
      check("s1_addr_c2", addr, 32'h1C00_0004);
      check("s1_ov_c2", 32'(out_valid), 32'd1);
      check("s1_pcout_c2", PC_out, 32'h1C00_0000);
      tick();
      check("s1_addr_c3", addr, 32'h1C00_0008);

      // Redirect while a request is mid-handshake
      do_reset();
      out_ready = 1; addr_ok = 0;
      tick();
      addr_ok = 1; tick();
      addr_ok = 0; tick();
      br_flush = 1; br_target = 32'h1C00_0100;
      tick();
      check("s2_addr_hold0", addr, 32'h1C00_0004);
      tick();
      tick();
      check("s2_addr_hold2", addr, 32'h1C00_0004);
      check("s2_req_hold2", 32'(req), 32'd1);
      addr_ok = 1; tick();
      check("s2_discard", 32'(discard_out), 32'd1);
      check("s2_no_load", 32'(out_valid), 32'd0);
      addr_ok = 0; tick();
      check("s2_new_req", 32'(req), 32'd1);
      check("s2_new_addr", addr, 32'h1C00_0100);
      check("s2_disc_count", 32'(disc_seen), 32'd1);

      // Flush priority
      do_reset();
      out_ready = 1; addr_ok = 0; tick();
      out_ready = 0; addr_ok = 1; tick();
      addr_ok = 0;
      ex_flush = 1; ex_entry = 32'h1C00_8000; br_flush = 1; br_target = 32'h1C00_0300;
      tick();
      check("s3_req", 32'(req), 32'd1);
      check("s3_addr", addr, 32'h1C00_8000);

      // Flush of a live request-backed slot
      do_reset();
      out_ready = 1; addr_ok = 0; tick();
      addr_ok = 1;
      for (int i = 0; i < 4; i++) tick();
      addr_ok = 0; tick();
      out_ready = 0; addr_ok = 1; tick();
      check("s4_slot_ov", 32'(out_valid), 32'd1);
      check("s4_slot_pc", PC_out, 32'h1C00_0010);
      addr_ok = 0; disc_seen = 0;
      ertn_flush = 1; era = 32'h1C00_0200;
      tick();
      check("s4_ov_clr", 32'(out_valid), 32'd0);
      check("s4_discard", 32'(discard_out), 32'd1);
      check("s4_addr", addr, 32'h1C00_0200);
      tick();
      check("s4_disc_count", 32'(disc_seen), 32'd1);

      // ADEF
      do_reset();
      out_ready = 1; addr_ok = 0; tick();
      br_flush = 1; br_target = 32'h1C00_0102; addr_ok = 1; tick();
      addr_ok = 0; tick();
      check("s5_ov", 32'(out_valid), 32'd1);
      check("s5_exc", 32'(has_exception_out), 32'd1);
      check("s5_ecode", 32'(ecode_out), 32'h08);
      check("s5_ivalid", 32'(inst_valid_out), 32'd1);
      check("s5_pcout", PC_out, 32'h1C00_0102);
      out_ready = 0; tick(); tick();
      out_ready = 1; tick(); tick(); tick();
      check("s5_req_idle", 32'(req), 32'd0);
      check("s5_no_reload", 32'(out_valid), 32'd0);
      br_flush = 1; br_target = 32'h1C00_0400; tick();
      check("s5_redir_req", 32'(req), 32'd1);
      check("s5_redir_addr", addr, 32'h1C00_0400);

      // Asynchronous reset mid-handshake
      do_reset();
      out_ready = 1; addr_ok = 0; tick();
      addr_ok = 1; tick();
      addr_ok = 0;
      #2 rst = 0;
      #1;
      check("s6_req_async", 32'(req), 32'd0);
      check("s6_ov_async", 32'(out_valid), 32'd0);
      check("s6_disc_async", 32'(discard_out), 32'd0);
      @(negedge clk);
      model_reset();
      rst = 1;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         out_ready  = ($urandom_range(0, 3) != 0);
         addr_ok    = ($urandom_range(0, 2) != 0) && !(m_slot && !out_ready);
         ex_flush   = ($urandom_range(0, 39) == 0);
         ertn_flush = ($urandom_range(0, 29) == 0);
         br_flush   = ($urandom_range(0, 15) == 0);
         ex_entry   = rand_target();
         era        = rand_target();
         br_target  = rand_target();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
